mltp_arbiter: RTL

//   Shares one sequential multiplier (mltp) among N_REQ requesters. Round-robin grant of
//   req/ack operand handshakes, one start pulse per grant, fixed-latency wait on the

---
 rtl/mltp_pkg.sv | 21 ++
 rtl/mltp_rr_pick.sv | 28 ++
 rtl/mltp_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mltp_pkg.sv
// mltp_pkg: shared types and constants for the multiplier arbiter.
package mltp_pkg;

    localparam int unsigned MLTP_LAT = 12;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned OPND_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Operand pair handed to the multiplier (B = multiplicand, Q = multiplier).
    typedef struct packed {
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] q;
    } opnd_t;

endpackage

// File: rtl/mltp_rr_pick.sv
// mltp_rr_pick: combinational round-robin picker; first set request at/after ptr, wrapping.
module mltp_rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner_c,
    output logic             any_c
);

    int unsigned idx;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        winner_c = '0;
        any_c    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!any_c && req[ID_W'(idx)]) begin
                winner_c = ID_W'(idx);
                any_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mltp_arbiter.sv
// mltp_arbiter: shares one sequential multiplier among N_REQ requesters with
// round-robin grant, a single start pulse per op and a fixed-latency wait.
// Optional statistics (op_cnt, wait_max) are built when MLTP_ARB_STATS_EN is defined.
module mltp_arbiter
    import mltp_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned MUL_LAT = MLTP_LAT,
    localparam int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                     CLK,
    input  logic                     Clr,
    input  logic [N_REQ-1:0]         req,
    input  logic [OPND_W*N_REQ-1:0]  b_in,
    input  logic [OPND_W*N_REQ-1:0]  q_in,
    output logic [N_REQ-1:0]         ack,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PROD_W-1:0]        rsp_prod,
    output logic                     busy,
    output logic                     mul_s,
    output logic [OPND_W-1:0]        mul_b,
    output logic [OPND_W-1:0]        mul_q_in,
    input  logic [OPND_W-1:0]        mul_a,
    input  logic [OPND_W-1:0]        mul_q
`ifdef MLTP_ARB_STATS_EN
    ,
    output logic [15:0]              op_cnt,
    output logic [7:0]               wait_max
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    arb_state_t          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     winner, winner_nxt;
    logic [N_REQ-1:0]    ack_nxt;
    logic                rsp_valid_nxt;
    logic [ID_W-1:0]     rsp_id_nxt;
    logic [PROD_W-1:0]   rsp_prod_nxt;
    logic                busy_nxt;
    logic                mul_s_nxt;
    opnd_t               opnd, opnd_nxt;
    opnd_t               opnd_arr [N_REQ];
    logic [ID_W-1:0]     pick_c;
    logic                any_c;

    // Per-requester operand view of the flat input buses.
    for (genvar g = 0; g < N_REQ; g++) begin : g_opnd
        assign opnd_arr[g] = '{b: b_in[g*OPND_W +: OPND_W], q: q_in[g*OPND_W +: OPND_W]};
    end

    mltp_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .winner_c (pick_c),
        .any_c    (any_c)
    );

    assign mul_b    = opnd.b;
    assign mul_q_in = opnd.q;

    // State register; shares the multiplier's negedge.
    always_ff @(negedge CLK or negedge Clr) begin
        if (!Clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        winner_nxt    = winner;
        ack_nxt       = '0;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rsp_id;
        rsp_prod_nxt  = rsp_prod;
        busy_nxt      = busy;
        mul_s_nxt     = 1'b0;
        opnd_nxt      = opnd;
        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (any_c) begin
                    winner_nxt = pick_c;
                    opnd_nxt   = opnd_arr[pick_c];
                    ack_nxt    = N_REQ'(1) << pick_c;
                    busy_nxt   = 1'b1;
                    state_nxt  = START;
                end
            end
            START: begin
                mul_s_nxt = 1'b1;
                cnt_nxt   = CNT_W'(MUL_LAT - 1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                rsp_prod_nxt  = {mul_a, mul_q};
                rsp_id_nxt    = winner;
                rsp_valid_nxt = 1'b1;
                ptr_nxt       = (32'(winner) == N_REQ - 1) ? '0 : winner + ID_W'(1);
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, latency counter and round-robin pointer.
    always_ff @(negedge CLK or negedge Clr) begin
        if (!Clr) begin
            cnt       <= '0;
            ptr       <= '0;
            winner    <= '0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            busy      <= 1'b0;
            mul_s     <= 1'b0;
            opnd      <= '0;
        end else begin
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            ack       <= ack_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_prod  <= rsp_prod_nxt;
            busy      <= busy_nxt;
            mul_s     <= mul_s_nxt;
            opnd      <= opnd_nxt;
        end
    end

`ifdef MLTP_ARB_STATS_EN
    logic [7:0] wcnt [N_REQ];
    logic [7:0] wait_max_nxt;

    // Per-requester count of edges spent requesting without a grant.
    for (genvar g = 0; g < N_REQ; g++) begin : g_wait
        logic [7:0] wc;
        always_ff @(negedge CLK or negedge Clr) begin
            if (!Clr) begin
                wc <= '0;
            end else if (ack_nxt[g] || !req[g]) begin
                wc <= '0;
            end else if (wc != 8'hFF) begin
                wc <= wc + 8'd1;
            end
        end
        assign wcnt[g] = wc;
    end

    // Only one requester is granted per edge, so only its wait can raise the max.
    always_comb begin
        wait_max_nxt = wait_max;
        if ((state == IDLE) && any_c && (wcnt[pick_c] > wait_max)) begin
            wait_max_nxt = wcnt[pick_c];
        end
    end

    // Completed-op counter (wrapping) and longest observed wait.
    always_ff @(negedge CLK or negedge Clr) begin
        if (!Clr) begin
            op_cnt   <= '0;
            wait_max <= '0;
        end else begin
            if (rsp_valid_nxt) begin
                op_cnt <= op_cnt + 16'd1;
            end
            wait_max <= wait_max_nxt;
        end
    end
`endif

endmodule
